// File: rtl/ibus_stream_port_if.sv
// ibus write/read port plus TX sink and RX source stream signals of ibus_stream_port.
// master = DMA/stream side, slave = the peripheral.
interface ibus_stream_port_if;
  logic        ibus_wen;
  logic [17:0] ibus_wadr;
  logic [15:0] ibus32_wdata;
  logic        ibus_ren;
  logic [17:0] ibus_radr;
  logic [15:0] ibus32_rdata;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;

  modport master (
    output ibus_wen, ibus_wadr, ibus32_wdata, ibus_ren, ibus_radr,
    input  ibus32_rdata,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready
  );

  modport slave (
    input  ibus_wen, ibus_wadr, ibus32_wdata, ibus_ren, ibus_radr,
    output ibus32_rdata,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready
  );
endinterface

// File: rtl/ibus_stream_port.sv
// ibus-mapped TX/RX stream FIFOs: DATA at BASE, STATUS at BASE+1, fixed 2-cycle read latency.
module ibus_stream_port #(
  parameter logic [17:0] BASE   = 18'h00100,
  parameter int unsigned FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_pipe,
  ibus_stream_port_if.slave bus
);
  localparam int unsigned       DEPTH    = 2 ** FDEPTH;
  localparam logic [FDEPTH:0]   CNT_FULL = {1'b1, {FDEPTH{1'b0}}};
  localparam logic [FDEPTH:0]   CNT_ONE  = {{FDEPTH{1'b0}}, 1'b1};
  localparam logic [FDEPTH-1:0] PTR_ONE  = {{(FDEPTH-1){1'b0}}, 1'b1};
  localparam logic [17:0]       ADR_STS  = BASE + 18'd1;

  logic [15:0] tx_mem [DEPTH];
  logic [15:0] rx_mem [DEPTH];

  logic [FDEPTH-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FDEPTH-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FDEPTH:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [15:0]       rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d;

  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        wr_data, wr_sts, rd_data, rd_sts;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [15:0] status;

  always_comb begin
    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == CNT_FULL);
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == CNT_FULL);

    wr_data = bus.ibus_wen && (bus.ibus_wadr == BASE);
    wr_sts  = bus.ibus_wen && (bus.ibus_wadr == ADR_STS);
    rd_data = bus.ibus_ren && (bus.ibus_radr == BASE);
    rd_sts  = bus.ibus_ren && (bus.ibus_radr == ADR_STS);

    // A full TX FIFO still accepts a write when its head leaves in the same cycle.
    tx_pop  = !tx_empty && bus.tx_ready;
    tx_push = wr_data && (!tx_full || tx_pop);
    rx_push = bus.rx_valid && !rx_full;
    rx_pop  = rd_data && !rx_empty;

    status = {10'd0, rx_udf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

    tx_wp_d  = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;

    tx_ovf_d = (wr_data && !tx_push) || (tx_ovf_q && !(wr_sts && bus.ibus32_wdata[4]));
    rx_udf_d = (rd_data && rx_empty) || (rx_udf_q && !(wr_sts && bus.ibus32_wdata[5]));

    rd_s1_d = '0;
    if (rx_pop)      rd_s1_d = rx_mem[rx_rp_q];
    else if (rd_sts) rd_s1_d = status;
    rd_s2_d = rd_s1_q;

    // Pipeline reset drops this cycle's capture but lets the older read finish.
    if (rst_pipe) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_cnt_d = '0;
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
      rd_s1_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      rd_s1_q  <= '0;
      rd_s2_q  <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      rd_s1_q  <= rd_s1_d;
      rd_s2_q  <= rd_s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= bus.ibus32_wdata;
    if (rx_push) rx_mem[rx_wp_q] <= bus.rx_data;
  end

  assign bus.tx_valid     = !tx_empty;
  assign bus.tx_data      = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign bus.rx_ready     = !rx_full;
  assign bus.ibus32_rdata = rd_s2_q;
endmodule

// File: tb/tb_ibus_stream_port.sv
// Directed and random stimulus for ibus_stream_port against a queue-based reference model.
module tb_ibus_stream_port;
  localparam logic [17:0] BASE = 18'h00100;
  localparam logic [17:0] STS  = BASE + 18'd1;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_pipe;

  ibus_stream_port_if bus ();

  ibus_stream_port #(.BASE(BASE), .FDEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_pipe (rst_pipe),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        m_ovf, m_udf;
  logic [15:0] m_s1, m_s2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_s1  = 16'h0;
    m_s2  = 16'h0;
  endtask

  task automatic idle();
    bus.ibus_wen     = 1'b0;
    bus.ibus_ren     = 1'b0;
    bus.rx_valid     = 1'b0;
    rst_pipe         = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d);
    bus.ibus_wen     = 1'b1;
    bus.ibus_wadr    = a;
    bus.ibus32_wdata = d;
  endtask

  task automatic rd(input logic [17:0] a);
    bus.ibus_ren  = 1'b1;
    bus.ibus_radr = a;
  endtask

  // Advance the model by one cycle from the driven inputs, clock the DUT, compare outputs.
  task automatic tick();
    int          ntx, nrx;
    logic        wr_d, wr_s, rd_d, rd_s, txpop, txacc, rxpush, rxpop, n_ovf, n_udf;
    logic [15:0] res, status;
    ntx    = txq.size();
    nrx    = rxq.size();
    status = {10'd0, m_udf, m_ovf, (nrx == 16), (nrx == 0), (ntx == 16), (ntx == 0)};
    wr_d   = bus.ibus_wen && (bus.ibus_wadr == BASE);
    wr_s   = bus.ibus_wen && (bus.ibus_wadr == STS);
    rd_d   = bus.ibus_ren && (bus.ibus_radr == BASE);
    rd_s   = bus.ibus_ren && (bus.ibus_radr == STS);
    res    = 16'h0;
    if (rd_d && nrx > 0) res = rxq[0];
    else if (rd_s)       res = status;
    txpop  = (ntx > 0) && bus.tx_ready;
    txacc  = wr_d && (ntx < 16 || txpop);
    rxpush = bus.rx_valid && (nrx < 16);
    rxpop  = rd_d && (nrx > 0);
    if (rst_pipe) begin
      txq.delete();
      rxq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_s2  = m_s1;
      m_s1  = 16'h0;
    end else begin
      n_ovf = (wr_d && !txacc) || (m_ovf && !(wr_s && bus.ibus32_wdata[4]));
      n_udf = (rd_d && nrx == 0) || (m_udf && !(wr_s && bus.ibus32_wdata[5]));
      if (txpop)  void'(txq.pop_front());
      if (txacc)  txq.push_back(bus.ibus32_wdata);
      if (rxpop)  void'(rxq.pop_front());
      if (rxpush) rxq.push_back(bus.rx_data);
      m_ovf = n_ovf;
      m_udf = n_udf;
      m_s2  = m_s1;
      m_s1  = res;
    end
    @(posedge clk);
    #1;
    check("tx_valid", 16'(bus.tx_valid), 16'(txq.size() > 0));
    check("tx_data", bus.tx_data, (txq.size() > 0) ? txq[0] : 16'h0);
    check("rx_ready", 16'(bus.rx_ready), 16'(rxq.size() < 16));
    check("rdata", bus.ibus32_rdata, m_s2);
    idle();
  endtask

  task automatic read_expect(input string tag, input logic [17:0] a, input logic [15:0] exp);
    rd(a);
    tick();
    tick();
    check(tag, bus.ibus32_rdata, exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_rdata", bus.ibus32_rdata, 16'h0000);
    check("rst_tx_valid", 16'(bus.tx_valid), 16'h0000);
    check("rst_tx_data", bus.tx_data, 16'h0000);
    check("rst_rx_ready", 16'(bus.rx_ready), 16'h0001);
  endtask

  initial begin
    rst_n            = 1'b1;
    bus.tx_ready     = 1'b0;
    bus.ibus_wadr    = '0;
    bus.ibus_radr    = '0;
    bus.ibus32_wdata = '0;
    bus.rx_data      = '0;
    idle();
    model_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    read_expect("sts_reset", STS, 16'h0005);

    // TX fill with sink stalled; 17th write overflows.
    for (int i = 1; i <= 17; i++) begin
      wr(BASE, 16'(i));
      tick();
    end
    read_expect("sts_txfull", STS, 16'h0016);
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("drain_order", bus.tx_data, 16'(i));
      tick();
    end
    check("tx_drained", 16'(bus.tx_valid), 16'h0000);

    wr(STS, 16'h0030);
    tick();
    read_expect("sts_clr_ovf", STS, 16'h0005);

    // RX fill, then 17 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 16'hA000 + 16'(i);
      tick();
    end
    check("rx_full_ready", 16'(bus.rx_ready), 16'h0000);
    for (int i = 0; i <= 17; i++) begin
      if (i < 17) rd(BASE);
      tick();
      if (i >= 1) check("rx_stream", bus.ibus32_rdata, (i <= 16) ? 16'hA000 + 16'(i - 1) : 16'h0000);
    end
    read_expect("sts_udf", STS, 16'h0025);

    // Underflow set and clear in the same cycle: set wins.
    rd(BASE);
    wr(STS, 16'h0020);
    tick();
    read_expect("sts_udf_set_wins", STS, 16'h0025);
    wr(STS, 16'h0030);
    tick();
    read_expect("sts_clr_udf", STS, 16'h0005);

    // Full TX with simultaneous pop and push across pointer wrap.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(BASE, 16'($urandom));
      tick();
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr(BASE, 16'($urandom));
      tick();
    end
    bus.tx_ready = 1'b0;
    read_expect("sts_full_no_ovf", STS, 16'h0006);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("tx_wrap_drained", 16'(bus.tx_valid), 16'h0000);

    // Pipeline reset one cycle after a read.
    bus.tx_ready = 1'b0;
    wr(BASE, 16'h5A5A);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 16'hB000 + 16'(i);
      tick();
    end
    rd(BASE);
    tick();
    rst_pipe = 1'b1;
    tick();
    check("pipe_rd_survives", bus.ibus32_rdata, 16'hB000);
    check("pipe_tx_empty", 16'(bus.tx_valid), 16'h0000);
    read_expect("sts_after_pipe", STS, 16'h0005);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.tx_ready = ($urandom_range(0, 9) < ((k < 200) ? 2 : 8));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0, 1:    wr(BASE, 16'($urandom));
          2:       wr(STS, 16'($urandom));
          default: wr(BASE + 18'd2, 16'($urandom));
        endcase
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    rd(BASE);
          2:       rd(STS);
          default: rd(BASE - 18'd1);
        endcase
      end
      bus.rx_valid = ($urandom_range(0, 1) == 1);
      bus.rx_data  = 16'($urandom);
      tick();
    end

    // Asynchronous reset mid-stream with a read in flight.
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 16'hC0DE;
    wr(BASE, 16'h1234);
    tick();
    rd(STS);
    tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    idle();
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_expect("sts_after_rst", STS, 16'h0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
